// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU sequencer: the opcode and state encodings,
// the bit positions of the N/Z/C/V flags, the operation-counter width, and a
// helper that decides whether a request can be sent to the ALU.
// Ports: none (package).

package alu_seq_pkg;

  localparam int OPS_CNT_W = 8;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_SUM  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MULT = 4'd2,
    OP_DIV  = 4'd3,
    OP_MOD  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // MULT is not in the external datapath, codes above SHR do not exist, and
  // a zero divisor for DIV/MOD is rejected before it reaches the ALU.
  function automatic logic op_executable(input logic [3:0] op, input logic [3:0] b);
    logic known;
    logic div0;
    known = (op <= 4'(OP_SHR)) && (op != 4'(OP_MULT));
    div0  = ((op == 4'(OP_DIV)) || (op == 4'(OP_MOD))) && (b == 4'd0);
    return known && !div0;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Accepts one ALU request at a time, drives registered operands to an
// external ALU, captures its result and flags after one execute cycle and
// presents them as a held response until the consumer takes it.
// Rejected requests (unknown op, MULT, divide by zero) skip the ALU and
// respond one cycle after acceptance with rsp_err=1 and zero payload.
//
// Optional feature (macro ALU_SEQ_ACC_EN): accumulator that loads each
// successful result; req_use_acc substitutes it for operand A. Without the
// macro req_use_acc is ignored and acc reads 0.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_op, req_a, req_b       opcode and operands
//   req_use_acc                use accumulator as operand A
//   alu_a, alu_b, alu_op       registered drive to the external ALU
//   alu_y, alu_n/z/c/v         ALU result and flags
//   rsp_valid/rsp_ready        response handshake
//   rsp_y, rsp_flags, rsp_err  response payload, flags as {N,Z,C,V}
//   acc, ops_cnt               accumulator, completed-operation counter

module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [3:0]           req_a,
  input  logic [3:0]           req_b,
  input  logic                 req_use_acc,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_op,
  input  logic [3:0]           alu_y,
  input  logic                 alu_n,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_v,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0]           rsp_y,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [3:0]           acc,
  output logic [OPS_CNT_W-1:0] ops_cnt
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_EXEC = ST_EXEC;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]           r_state;
  logic [3:0]           r_alu_a;
  logic [3:0]           r_alu_b;
  logic [3:0]           r_alu_op;
  logic [3:0]           r_rsp_y;
  logic [3:0]           r_rsp_flags;
  logic                 r_rsp_err;
  logic [OPS_CNT_W-1:0] r_ops_cnt;

  logic       w_accept;
  logic       w_resp_done;
  logic [3:0] w_opnd_a;
  logic [3:0] w_acc;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_resp_done = (r_state == S_RESP) && rsp_ready;

`ifdef ALU_SEQ_ACC_EN
  logic [3:0] r_acc;

  assign w_opnd_a = req_use_acc ? r_acc : req_a;
  assign w_acc    = r_acc;

  // Only a successful response updates the accumulator; errors leave it as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_resp_done && !r_rsp_err) begin
      r_acc <= r_rsp_y;
    end
  end
`else
  logic w_unused_use_acc;

  assign w_unused_use_acc = req_use_acc;
  assign w_opnd_a         = req_a;
  assign w_acc            = '0;
`endif

  // Response payload registers are written only on the way into RESP, so they
  // stay stable for as long as the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_y     <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
      r_ops_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op_executable(req_op, req_b)) begin
              r_alu_a  <= w_opnd_a;
              r_alu_b  <= req_b;
              r_alu_op <= req_op;
              r_state  <= S_EXEC;
            end else begin
              r_rsp_y     <= '0;
              r_rsp_flags <= '0;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_EXEC: begin
          r_rsp_y             <= alu_y;
          r_rsp_flags[FLAG_N] <= alu_n;
          r_rsp_flags[FLAG_Z] <= alu_z;
          r_rsp_flags[FLAG_C] <= alu_c;
          r_rsp_flags[FLAG_V] <= alu_v;
          r_rsp_err           <= 1'b0;
          r_state             <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ops_cnt <= r_ops_cnt + OPS_CNT_W'(1);
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_y     = r_rsp_y;
  assign rsp_flags = r_rsp_flags;
  assign rsp_err   = r_rsp_err;
  assign acc       = w_acc;
  assign ops_cnt   = r_ops_cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Drives alu_sequencer with directed and random requests, stands in for the
// external ALU, and compares every response against a transaction-level
// model of the sequencer (legality rules, accumulator, operation count).
// Optional feature macro: ALU_SEQ_ACC_EN (model follows the same define).

module tb_alu_sequencer;

`ifdef ALU_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic       req_use_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_op;
  logic [3:0] alu_y;
  logic       alu_n;
  logic       alu_z;
  logic       alu_c;
  logic       alu_v;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_y;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic [3:0] acc;
  logic [7:0] ops_cnt;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  int modelAcc = 0;
  int modelCnt = 0;
  int opsSinceReset = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .acc(acc), .ops_cnt(ops_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour: returns {y[3:0], N, Z, C, V}
  function automatic logic [7:0] aluRef(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ai, bi, s;
    logic [3:0] y;
    logic c, v;
    ai = int'(a);
    bi = int'(b);
    y = 4'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = ai + bi;
        y = 4'(s);
        c = (s > 15);
        v = (a[3] == b[3]) && (y[3] != a[3]);
      end
      4'd1: begin
        s = ai - bi;
        y = 4'(s);
        c = (ai < bi);
        v = (a[3] != b[3]) && (y[3] != a[3]);
      end
      4'd3: y = (bi == 0) ? 4'd0 : 4'(ai / bi);
      4'd4: y = (bi == 0) ? 4'd0 : 4'(ai % bi);
      4'd5: y = a & b;
      4'd6: y = a | b;
      4'd7: y = a ^ b;
      4'd8: y = (bi > 3) ? 4'd0 : 4'(ai * (1 << bi));
      4'd9: y = (bi > 3) ? 4'd0 : 4'(ai / (1 << bi));
      default: y = 4'd0;
    endcase
    return {y, y[3], (y == 4'd0), c, v};
  endfunction

  // Stand-in for the external ALU next to the sequencer
  always_comb begin
    {alu_y, alu_n, alu_z, alu_c, alu_v} = aluRef(alu_op, alu_a, alu_b);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete request/response exchange, starting and ending at a negedge in IDLE.
  // While the sequencer is busy, req_valid stays high with junk so that any
  // sampling outside the accept edge (including the RESP exit edge) shows up.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic useAcc, input int stall);
    logic ok;
    logic [3:0] aEff;
    logic [7:0] r;
    ok   = (op <= 4'd9) && (op != 4'd2) && !(((op == 4'd3) || (op == 4'd4)) && (b == 4'd0));
    aEff = (ACC_EN && useAcc) ? 4'(modelAcc) : a;
    r    = ok ? aluRef(op, aEff, b) : 8'd0;

    checkOutput("req_ready_idle", req_ready, 1);
    req_valid   = 1'b1;
    req_op      = op;
    req_a       = a;
    req_b       = b;
    req_use_acc = useAcc;
    @(negedge clk);
    req_op      = 4'($urandom);
    req_a       = 4'($urandom);
    req_b       = 4'($urandom);
    req_use_acc = 1'($urandom);
    checkOutput("req_ready_busy", req_ready, 0);
    if (ok) begin
      checkOutput("rsp_valid_exec", rsp_valid, 0);
      checkOutput("alu_a", alu_a, aEff);
      checkOutput("alu_b", alu_b, b);
      checkOutput("alu_op", alu_op, op);
      @(negedge clk);
      req_op = 4'($urandom);
      req_a  = 4'($urandom);
    end
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_y", rsp_y, r[7:4]);
    checkOutput("rsp_flags", rsp_flags, r[3:0]);
    checkOutput("rsp_err", rsp_err, !ok);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_b = 4'($urandom);
      checkOutput("stall_valid", rsp_valid, 1);
      checkOutput("stall_ready", req_ready, 0);
      checkOutput("stall_y", rsp_y, r[7:4]);
      checkOutput("stall_flags", rsp_flags, r[3:0]);
      checkOutput("stall_err", rsp_err, !ok);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    modelCnt = (modelCnt + 1) % 256;
    opsSinceReset++;
    if (ACC_EN && ok) modelAcc = int'(r[7:4]);
    checkOutput("exit_rsp_valid", rsp_valid, 0);
    checkOutput("exit_req_ready", req_ready, 1);
    checkOutput("ops_cnt", ops_cnt, modelCnt);
    checkOutput("acc", acc, modelAcc);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b1;
    req_op      = 4'd0;
    req_a       = 4'd5;
    req_b       = 4'd6;
    req_use_acc = 1'b0;
    rsp_ready   = 1'b1;
    repeat (3) @(negedge clk);

    // Outputs while held in reset
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_y", rsp_y, 0);
    checkOutput("rst_rsp_flags", rsp_flags, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_acc", acc, 0);
    checkOutput("rst_ops_cnt", ops_cnt, 0);

    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Reset pulsed while the operation is in EXEC: dropped without response
    req_valid = 1'b1;
    req_op    = 4'd0;
    req_a     = 4'd1;
    req_b     = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mid_in_exec", req_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", rsp_valid, 0);
    checkOutput("mid_rst_ready", req_ready, 1);
    checkOutput("mid_rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("mid_no_rsp", rsp_valid, 0);
      checkOutput("mid_ready", req_ready, 1);
      checkOutput("mid_ops_cnt", ops_cnt, 0);
    end

    // Directed cases
    applyStimulus(4'd0, 4'd3, 4'd4, 1'b0, 0);
    checkOutput("sum_cnt_one", ops_cnt, 1);
    applyStimulus(4'hC, 4'd7, 4'd1, 1'b0, 0);
    applyStimulus(4'd2, 4'd3, 4'd3, 1'b0, 1);
    applyStimulus(4'd3, 4'd5, 4'd0, 1'b0, 0);
    applyStimulus(4'd3, 4'd9, 4'd3, 1'b0, 0);
    applyStimulus(4'd0, 4'd3, 4'd4, 1'b0, 0);
    applyStimulus(4'd1, 4'd2, 4'd7, 1'b1, 0);
`ifdef ALU_SEQ_ACC_EN
    checkOutput("acc_sub_alu_a", alu_a, 7);
    checkOutput("acc_sub_zero", acc, 0);
`endif
    applyStimulus(4'd7, 4'd10, 4'd6, 1'b0, 5);
    applyStimulus(4'd4, 4'd11, 4'd0, 1'b0, 2);
    applyStimulus(4'd8, 4'd3, 4'd2, 1'b0, 0);
    applyStimulus(4'd9, 4'd12, 4'd5, 1'b0, 0);

    // Random traffic until exactly 256 operations since reset, so the counter wraps
    while (opsSinceReset < 256) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                    1'($urandom), int'($urandom_range(0, 2)));
    end
    checkOutput("ops_cnt_wrap", ops_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
